// File: rtl/bip_acc_alu.sv
// -----------------------------------------------------------------------------
// bip_acc_alu -- registered accumulator ALU for the BIP datapath.
//
// Accepts one op + operand through a valid/ready handshake, holds it for LAT
// cycles, then commits the result into the accumulator. The flags update on the
// same edge, and a one-cycle out_valid strobe marks the commit.
//
// Parameters:
//   N   : data/accumulator width (4..32)
//   LAT : cycles from acceptance edge to commit edge (1..4)
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : op handshake; in_ready depends on FSM state only
//   op [2:0]            : 000 NOP, 001 LD, 010 ADD, 011 SUB, 100 CLR, others NOP
//   operand [N-1:0]     : raw operand bits
//   acc [N-1:0]         : registered accumulator
//   out_valid           : one-cycle pulse after each commit
//   carry, ovf, zero, neg : status flags of the last non-NOP commit
//
// Optional feature macro: BIP_ACC_SAT_EN
//   Defined   -> ADD/SUB results that overflow clamp to signed max/min.
//   Undefined -> two's-complement wrap (no clamp logic).
// -----------------------------------------------------------------------------
module bip_acc_alu #(
    parameter int N   = 16,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] operand,
    output logic [N-1:0] acc,
    output logic         out_valid,
    output logic         carry,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_CLR = 3'b100;

    // The counter starts at LAT-1 on acceptance. The commit happens on the
    // BUSY edge where it reads zero, so the commit falls exactly LAT edges
    // after acceptance.
    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state_reg;
    logic [1:0]   cnt_reg;
    logic [2:0]   op_reg;
    logic [N-1:0] operand_reg;

    logic [N:0]   sum_ext;
    logic [N:0]   diff_ext;
    logic [N-1:0] acc_next;
    logic         carry_next;
    logic         ovf_next;
    logic         flags_upd;

    assign in_ready = (state_reg == IDLE);

    // Computed in N+1 bits. The MSB of sum_ext is the carry. The MSB of
    // diff_ext is the borrow, which is set exactly when acc < operand (unsigned).
    assign sum_ext  = {1'b0, acc} + {1'b0, operand_reg};
    assign diff_ext = {1'b0, acc} - {1'b0, operand_reg};

    always_comb begin
        acc_next   = acc;
        carry_next = carry;
        ovf_next   = ovf;
        flags_upd  = 1'b0;
        case (op_reg)
            OP_LD: begin
                acc_next   = operand_reg;
                carry_next = 1'b0;
                ovf_next   = 1'b0;
                flags_upd  = 1'b1;
            end
            OP_ADD: begin
                acc_next   = sum_ext[N-1:0];
                carry_next = sum_ext[N];
                ovf_next   = (acc[N-1] == operand_reg[N-1]) &&
                             (sum_ext[N-1] != acc[N-1]);
                flags_upd  = 1'b1;
            end
            OP_SUB: begin
                acc_next   = diff_ext[N-1:0];
                carry_next = diff_ext[N];
                ovf_next   = (acc[N-1] != operand_reg[N-1]) &&
                             (diff_ext[N-1] != acc[N-1]);
                flags_upd  = 1'b1;
            end
            OP_CLR: begin
                acc_next   = '0;
                carry_next = 1'b0;
                ovf_next   = 1'b0;
                flags_upd  = 1'b1;
            end
            default: ; // NOP and the reserved codes leave everything unchanged
        endcase
`ifdef BIP_ACC_SAT_EN
        // The overflow direction follows the sign of acc. For ADD, both
        // operands share that sign. For SUB, a positive acc can only overflow
        // upward.
        if ((op_reg == OP_ADD || op_reg == OP_SUB) && ovf_next) begin
            acc_next = acc[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            op_reg      <= OP_NOP;
            operand_reg <= '0;
            acc         <= '0;
            out_valid   <= 1'b0;
            carry       <= 1'b0;
            ovf         <= 1'b0;
            zero        <= 1'b0;
            neg         <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg      <= op;
                        operand_reg <= operand;
                        cnt_reg     <= CNT_INIT;
                        state_reg   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 2'd0) begin
                        acc       <= acc_next;
                        carry     <= carry_next;
                        ovf       <= ovf_next;
                        if (flags_upd) begin
                            zero <= (acc_next == '0);
                            neg  <= acc_next[N-1];
                        end
                        out_valid <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 2'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
